// File: rtl/bcd_pkg.sv
// Shared types, limits and helpers for the BCD timer counter.
// Imported by the digit slice and by the top level.
package bcd_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;
    localparam digit_t BCD_MIN = 4'd0;

    // Loaded digits above 9 are forced to 9 so BCD never shows a non-decimal code.
    function automatic digit_t clamp_digit(input digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int prescale_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One decimal digit of the up/down chain: next value plus carry/borrow
// terminal conditions for the digit above.
module bcd_updown_digit
    import bcd_pkg::*;
(
    input  logic   step_i,
    input  logic   up_i,
    input  digit_t digit_i,
    output digit_t digit_o,
    output logic   carry_o,
    output logic   borrow_o
);

    // Terminal conditions depend only on the stored digit, never on step_i,
    // so the ripple chain above this slice stays free of combinational loops.
    assign carry_o  = up_i && (digit_i == BCD_MAX);
    assign borrow_o = !up_i && (digit_i == BCD_MIN);

    always_comb begin
        // NOTE: default assigned first so every path drives digit_o and no latch is inferred.
        digit_o = digit_i;
        if (step_i) begin
            if (up_i) digit_o = carry_o  ? BCD_MIN : digit_i + 4'd1;
            else      digit_o = borrow_o ? BCD_MAX : digit_i - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up/down timer with tick prescaler, parallel load,
// wrap/saturate limit handling and sticky range flags.
module bcd_timer_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Clear,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Tick,
    output logic                  Overflow,
    output logic                  Underflow,
    output logic                  Zero
);

    localparam int            PW      = prescale_width(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]             presc_q, presc_d;
    digit_t [DIGITS-1:0]       digit_q, digit_d, digit_step;
    logic   [DIGITS-1:0]       step_in, carry, borrow;
    logic                      ovf_q, ovf_d, unf_q, unf_d;
    logic                      all_max, all_min;

    assign Tick = Enable && (presc_q == PS_LAST);

    // Digit i steps only when the step reaches it through every lower digit.
    always_comb begin
        step_in[0] = Tick;
        for (int i = 1; i < DIGITS; i++)
            step_in[i] = step_in[i-1] & (carry[i-1] | borrow[i-1]);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_updown_digit u_digit (
            .step_i   (step_in[g]),
            .up_i     (Up),
            .digit_i  (digit_q[g]),
            .digit_o  (digit_step[g]),
            .carry_o  (carry[g]),
            .borrow_o (borrow[g])
        );
    end

    assign all_max = &carry;
    assign all_min = &borrow;

    always_comb begin
        digit_d = digit_q;
        presc_d = presc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (Clear) begin
            digit_d = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (Load) begin
            for (int i = 0; i < DIGITS; i++)
                digit_d[i] = clamp_digit(LoadValue[4*i +: 4]);
            presc_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (Enable) begin
            presc_d = Tick ? '0 : presc_q + PW'(1);
            if (Tick) begin
                if (all_max) begin
                    ovf_d   = 1'b1;
                    digit_d = SATURATE ? digit_q : '0;
                end else if (all_min) begin
                    unf_d   = 1'b1;
                    digit_d = SATURATE ? digit_q : {DIGITS{BCD_MAX}};
                end else begin
                    digit_d = digit_step;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            digit_q <= '0;
            presc_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            digit_q <= digit_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign BCD       = digit_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Zero      = (digit_q == '0);

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench: a vector table on a wrap/PRESCALE=1 instance plus hand-written
// sequences for prescaling, saturation, pause and asynchronous reset.
module tb_bcd_timer_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DIGITS=2, PRESCALE=3, SATURATE=1
    logic a_rst_n, a_clr, a_en, a_up, a_ld;
    logic [7:0] a_lv, a_bcd;
    logic a_tick, a_ovf, a_unf, a_zero;
    // Instance B: DIGITS=2, PRESCALE=1, SATURATE=0
    logic b_rst_n, b_clr, b_en, b_up, b_ld;
    logic [7:0] b_lv, b_bcd;
    logic b_tick, b_ovf, b_unf, b_zero;
    // Instance C: DIGITS=2, PRESCALE=4, SATURATE=1
    logic c_rst_n, c_clr, c_en, c_up, c_ld;
    logic [7:0] c_lv, c_bcd;
    logic c_tick, c_ovf, c_unf, c_zero;

    bcd_timer_counter #(.DIGITS(2), .PRESCALE(3), .SATURATE(1'b1)) dut_a (
        .Clock(clk), .Resetn(a_rst_n), .Clear(a_clr), .Enable(a_en), .Up(a_up),
        .Load(a_ld), .LoadValue(a_lv), .BCD(a_bcd), .Tick(a_tick),
        .Overflow(a_ovf), .Underflow(a_unf), .Zero(a_zero));

    bcd_timer_counter #(.DIGITS(2), .PRESCALE(1), .SATURATE(1'b0)) dut_b (
        .Clock(clk), .Resetn(b_rst_n), .Clear(b_clr), .Enable(b_en), .Up(b_up),
        .Load(b_ld), .LoadValue(b_lv), .BCD(b_bcd), .Tick(b_tick),
        .Overflow(b_ovf), .Underflow(b_unf), .Zero(b_zero));

    bcd_timer_counter #(.DIGITS(2), .PRESCALE(4), .SATURATE(1'b1)) dut_c (
        .Clock(clk), .Resetn(c_rst_n), .Clear(c_clr), .Enable(c_en), .Up(c_up),
        .Load(c_ld), .LoadValue(c_lv), .BCD(c_bcd), .Tick(c_tick),
        .Overflow(c_ovf), .Underflow(c_unf), .Zero(c_zero));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // One table row: inputs held across one rising edge, outputs sampled after it.
    typedef struct {
        logic       clr, ld, en, up;
        logic [7:0] lv;
        logic [7:0] bcd;
        logic       tick, ovf, unf, zero;
    } vec_t;

    function automatic vec_t mk(input logic clr, ld, en, up, input logic [7:0] lv,
                                input logic [7:0] bcd, input logic tick, ovf, unf, zero);
        vec_t v;
        v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
        v.bcd = bcd; v.tick = tick; v.ovf = ovf; v.unf = unf; v.zero = zero;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        //             clr   ld    en    up    lv     bcd    tick  ovf   unf   zero
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hFA, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h39, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h89, 1'b1, 1'b0, 1'b0, 1'b0);

        {a_rst_n, a_clr, a_en, a_up, a_ld, a_lv} = '0;
        {b_rst_n, b_clr, b_en, b_up, b_ld, b_lv} = '0;
        {c_rst_n, c_clr, c_en, c_up, c_ld, c_lv} = '0;

        // Reset state of all three instances
        #2;
        check("reset_a", {a_bcd, a_tick, a_ovf, a_unf, a_zero}, {8'h00, 4'b0001});
        check("reset_b", {b_bcd, b_tick, b_ovf, b_unf, b_zero}, {8'h00, 4'b0001});
        check("reset_c", {c_bcd, c_tick, c_ovf, c_unf, c_zero}, {8'h00, 4'b0001});

        // Instance A: free-running up count from reset, one step every 3 cycles
        @(negedge clk);
        a_rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
        b_rst_n = 1'b1; c_rst_n = 1'b1;
        for (int c = 0; c < 90; c++) begin
            #1;
            check($sformatf("run_tick_c%0d", c), 32'(a_tick), 32'(c % 3 == 2));
            check($sformatf("run_bcd_c%0d", c), 32'(a_bcd), 32'(to_bcd(c / 3)));
            @(negedge clk);
        end
        #1 check("run_30_steps", 32'(a_bcd), 32'h30);

        // Instance A: saturation at 99 with sticky Overflow, then Clear
        a_ld = 1'b1; a_lv = 8'h98;
        run(1);
        a_ld = 1'b0;
        check("sat_load98", {a_bcd, a_ovf}, {8'h98, 1'b0});
        run(3);
        check("sat_step1", {a_bcd, a_ovf}, {8'h99, 1'b0});
        run(3);
        check("sat_step2", {a_bcd, a_ovf}, {8'h99, 1'b1});
        run(3);
        check("sat_step3", {a_bcd, a_ovf}, {8'h99, 1'b1});
        a_clr = 1'b1;
        run(1);
        a_clr = 1'b0;
        check("sat_clear", {a_bcd, a_ovf, a_zero}, {8'h00, 1'b0, 1'b1});

        // Instance B: table of single-cycle vectors (PRESCALE=1, wrap mode)
        foreach (vecs[i]) begin
            @(negedge clk);
            b_clr = vecs[i].clr; b_ld = vecs[i].ld; b_en = vecs[i].en;
            b_up = vecs[i].up;   b_lv = vecs[i].lv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {b_bcd, b_tick, b_ovf, b_unf, b_zero},
                  {vecs[i].bcd, vecs[i].tick, vecs[i].ovf, vecs[i].unf, vecs[i].zero});
        end
        @(negedge clk);
        {b_clr, b_ld, b_en} = '0;

        // Instance C: pause keeps the prescaler phase
        c_en = 1'b1; c_up = 1'b1;
        run(2);
        c_en = 1'b0;
        run(5);
        #1 check("pause_hold", {c_bcd, c_tick}, {8'h00, 1'b0});
        c_en = 1'b1;
        #1 check("pause_resume_tick0", 32'(c_tick), 32'd0);
        run(1);
        #1 check("pause_tick_edge", {c_bcd, c_tick}, {8'h00, 1'b1});
        run(1);
        #1 check("pause_stepped", {c_bcd, c_tick}, {8'h01, 1'b0});

        // Instance A: async reset mid-count at 57 with Overflow set
        a_ld = 1'b1; a_lv = 8'h99; a_en = 1'b1; a_up = 1'b1;
        run(1);
        a_ld = 1'b0;
        run(3);
        a_up = 1'b0;
        run(126);
        check("areset_pre", {a_bcd, a_ovf, a_unf}, {8'h57, 1'b1, 1'b0});
        a_en = 1'b0;
        #2 a_rst_n = 1'b0;
        #1 check("areset_now", {a_bcd, a_ovf, a_zero}, {8'h00, 1'b0, 1'b1});
        @(negedge clk);
        a_rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
        #1 check("areset_rel_tick", 32'(a_tick), 32'd0);
        run(2);
        #1 check("areset_period", {a_bcd, a_tick}, {8'h00, 1'b1});
        run(1);
        #1 check("areset_resume", {a_bcd, a_tick}, {8'h01, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_timer_counter.md
Name: bcd_timer_counter

Overview:
Parametrised multi-digit BCD up/down counter with built-in tick prescaler, parallel load and selectable wrap/saturate limit handling. It is the timing core of the reaction tester. The prescaler divides the system clock to a count tick (default 1 ms at 50 MHz). The BCD digits drive the seven-segment decoders directly. Sticky range flags report overrun to the control FSM.

Parameters:
DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
PRESCALE, 50000, enabled clock cycles per count step (>=1; 1 = step every enabled cycle).
SATURATE, 1, 1 = hold at limit, 0 = wrap around at limit.

Ports:
Clock  in  1  system clock; all state changes on the rising edge.
Resetn  in  1  asynchronous, active-low reset.
Clear  in  1  synchronous clear: digits, prescaler and flags go to 0.
Enable  in  1  prescaler and counter advance only while high.
Up  in  1  count direction: 1 = increment, 0 = decrement.
Load  in  1  synchronous parallel load of LoadValue.
LoadValue  in  4*DIGITS  packed BCD load value; digit i is in bits [4i+3:4i].
BCD  out  4*DIGITS  packed BCD count.
Tick  out  1  combinational; high in a cycle where Enable=1 and prescaler = PRESCALE-1 (a step occurs on that edge).
Overflow  out  1  sticky; set when an up-step is attempted at all-9s.
Underflow  out  1  sticky; set when a down-step is attempted at all-0s.
Zero  out  1  combinational; high when BCD is all 0.

Behaviour:
- Resetn low (asynchronous): BCD=0, prescaler=0, Overflow=0, Underflow=0. Zero=1; Tick=0 while Enable=0 or PRESCALE>1.
- Priority at each rising edge: Clear > Load > step > hold.
- Clear: BCD=0, prescaler=0, both flags=0. Clear ignores Enable.
- Load: each LoadValue digit is written into BCD; any digit >9 is clamped to 9. Prescaler goes to 0 and both flags go to 0. Load ignores Enable.
- Prescaler counts 0..PRESCALE-1 while Enable=1. On the Tick edge it returns to 0. While Enable=0 it holds its value (pause, not restart).
- Step on a Tick edge, Up=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. Carries ripple through all digits in the same cycle (single-cycle latency).
- Step on a Tick edge, Up=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Upper limit (all 9s, Up=1): SATURATE=1 holds the value; SATURATE=0 wraps to all 0s. Overflow sets in both modes.
- Lower limit (all 0s, Up=0): SATURATE=1 holds the value; SATURATE=0 wraps to all 9s. Underflow sets in both modes.
- Flags stay set until Resetn, Clear or Load.
- Up may change on any cycle; the value sampled on the Tick edge is used.
- Internal digit values are always 0..9; no out-of-range digit may ever reach BCD.
- Resetn asserted mid-count takes effect immediately, without waiting for Clock. After release, counting resumes from 0 on the first full prescale period.
- PRESCALE=1: the prescaler register is width 1 and is held at 0; Tick = Enable.

Decomposition:
- Shared package bcd_pkg holds:
  - the 4-bit digit type;
  - constants BCD_MAX=9 and BCD_MIN=0;
  - a clamp-to-9 helper function;
  - a function for the prescaler counter width (ceil log2 of PRESCALE, minimum 1).
- Sub-module bcd_updown_digit (one per digit, generate loop):
  - inputs: step, up, digit value;
  - outputs: next digit, carry_out (digit=9 and up), borrow_out (digit=0 and down).
- Top level holds:
  - the prescaler;
  - the carry/borrow chain, AND-ing step with the lower-digit terminal conditions;
  - the all-9s/all-0s detection for saturate, wrap and flag handling;
  - the load/clear muxing.

Test Plan:
- DIGITS=2, PRESCALE=3, Up=1, Enable=1 from reset -> BCD steps 00,01,02 every 3 cycles; Tick high on every 3rd cycle; after 30 steps BCD=30.
- DIGITS=2, SATURATE=1: Load 98, count up 3 steps -> 99, 99, 99; Overflow goes high on the 2nd step and stays high; Clear -> BCD=00, Overflow=0.
- DIGITS=2, SATURATE=0: Load 01, Up=0, 3 steps -> 00, 99 (Underflow=1), 98; Zero high only while BCD=00.
- Load 4'hF,4'hA (digits 1,0) -> BCD=99. Load and Clear in the same cycle -> BCD=00 (Clear wins).
- PRESCALE=4, Enable drops after 2 prescaler cycles for 5 cycles, then rises -> next step occurs 2 enabled cycles after Enable returns (prescaler paused, not reset).
- Resetn pulsed low between clock edges while BCD=57 and Overflow=1 -> BCD=00 and Overflow=0 immediately; count resumes from 00 after release.
